// File: rtl/asfifo_level_if.sv
// Handshake and data bundle between a FIFO user and asfifo_level.
interface asfifo_level_if #(
  parameter int unsigned data_width    = 8,
  parameter int unsigned address_width = 4
);
  logic [data_width-1:0]  data_in;
  logic                   write_en;
  logic                   full;
  logic                   almost_full;
  logic [address_width:0] wr_level;
  logic                   overflow;
  logic [data_width-1:0]  data_out;
  logic                   read_en;
  logic                   empty;
  logic                   almost_empty;
  logic [address_width:0] rd_level;
  logic                   underflow;

  modport master (
    output data_in, write_en, read_en,
    input  full, almost_full, wr_level, overflow,
    input  data_out, empty, almost_empty, rd_level, underflow
  );

  modport slave (
    input  data_in, write_en, read_en,
    output full, almost_full, wr_level, overflow,
    output data_out, empty, almost_empty, rd_level, underflow
  );
endinterface

// File: rtl/asfifo_level.sv
// Asynchronous FIFO with Gray-coded pointer crossing, fill levels,
// almost-full/almost-empty flags and overflow/underflow pulses.
module asfifo_level #(
  parameter int unsigned data_width          = 8,
  parameter int unsigned address_width       = 4,
  parameter int unsigned sync_stages         = 2,
  parameter int unsigned almost_full_thresh  = 12,
  parameter int unsigned almost_empty_thresh = 4
) (
  input logic          clk_write,
  input logic          preset_full,
  input logic          clk_read,
  asfifo_level_if.slave bus
);

  localparam int unsigned depth = 2 ** address_width;
  localparam int unsigned PW    = address_width + 1;

  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t depth_p   = PW'(depth);
  localparam ptr_t af_thresh = PW'(almost_full_thresh);
  localparam ptr_t ae_thresh = PW'(almost_empty_thresh);

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [sync_stages-1:0] wr_rst_q, rd_rst_q;
  logic                   wr_rst, rd_rst;

  logic [data_width-1:0] mem_q [depth];

  ptr_t wr_ptr_q, wr_ptr_d, wr_gray_q, wr_level_q, wr_level_d;
  logic full_q, full_d, af_q, af_d, overflow_q, overflow_d, wr_fire;
  logic [sync_stages-1:0][PW-1:0] rd_gray_sync_q;

  ptr_t rd_ptr_q, rd_ptr_d, rd_gray_q, rd_level_q, rd_level_d;
  logic empty_q, empty_d, ae_q, ae_d, underflow_q, underflow_d, rd_fire;
  logic [sync_stages-1:0][PW-1:0] wr_gray_sync_q;

  // Write-domain reset: asserts immediately, releases after sync_stages edges.
  always_ff @(posedge clk_write or posedge preset_full) begin
    if (preset_full) wr_rst_q <= '1;
    else             wr_rst_q <= {wr_rst_q[sync_stages-2:0], 1'b0};
  end

  // Read-domain reset: same scheme on clk_read.
  always_ff @(posedge clk_read or posedge preset_full) begin
    if (preset_full) rd_rst_q <= '1;
    else             rd_rst_q <= {rd_rst_q[sync_stages-2:0], 1'b0};
  end

  assign wr_rst = wr_rst_q[sync_stages-1];
  assign rd_rst = rd_rst_q[sync_stages-1];

  // Storage array; contents are logically discarded by pointer reset.
  always_ff @(posedge clk_write) begin
    if (wr_fire) mem_q[wr_ptr_q[address_width-1:0]] <= bus.data_in;
  end

  // Write-side next state: level measured against the synced read pointer.
  always_comb begin
    wr_fire    = bus.write_en & ~full_q;
    wr_ptr_d   = wr_ptr_q + PW'(wr_fire);
    wr_level_d = wr_ptr_d - gray2bin(rd_gray_sync_q[sync_stages-1]);
    full_d     = (wr_level_d == depth_p);
    af_d       = (wr_level_d >= af_thresh);
    overflow_d = bus.write_en & full_q;
  end

  // Write-side state, Gray pointer and read-pointer synchroniser.
  always_ff @(posedge clk_write or posedge wr_rst) begin
    if (wr_rst) begin
      wr_ptr_q       <= '0;
      wr_gray_q      <= '0;
      rd_gray_sync_q <= '0;
      wr_level_q     <= '0;
      full_q         <= 1'b1;
      af_q           <= 1'b1;
      overflow_q     <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      wr_gray_q      <= bin2gray(wr_ptr_d);
      rd_gray_sync_q <= {rd_gray_sync_q[sync_stages-2:0], rd_gray_q};
      wr_level_q     <= wr_level_d;
      full_q         <= full_d;
      af_q           <= af_d;
      overflow_q     <= overflow_d;
    end
  end

  // Read-side next state: level measured against the synced write pointer.
  always_comb begin
    rd_fire     = bus.read_en & ~empty_q;
    rd_ptr_d    = rd_ptr_q + PW'(rd_fire);
    rd_level_d  = gray2bin(wr_gray_sync_q[sync_stages-1]) - rd_ptr_d;
    empty_d     = (rd_level_d == '0);
    ae_d        = (rd_level_d <= ae_thresh);
    underflow_d = bus.read_en & empty_q;
  end

  // Read-side state, Gray pointer and write-pointer synchroniser.
  always_ff @(posedge clk_read or posedge rd_rst) begin
    if (rd_rst) begin
      rd_ptr_q       <= '0;
      rd_gray_q      <= '0;
      wr_gray_sync_q <= '0;
      rd_level_q     <= '0;
      empty_q        <= 1'b1;
      ae_q           <= 1'b1;
      underflow_q    <= 1'b0;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      rd_gray_q      <= bin2gray(rd_ptr_d);
      wr_gray_sync_q <= {wr_gray_sync_q[sync_stages-2:0], wr_gray_q};
      rd_level_q     <= rd_level_d;
      empty_q        <= empty_d;
      ae_q           <= ae_d;
      underflow_q    <= underflow_d;
    end
  end

  assign bus.full         = full_q;
  assign bus.almost_full  = af_q;
  assign bus.wr_level     = wr_level_q;
  assign bus.overflow     = overflow_q;
  assign bus.data_out     = mem_q[rd_ptr_q[address_width-1:0]];
  assign bus.empty        = empty_q;
  assign bus.almost_empty = ae_q;
  assign bus.rd_level     = rd_level_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_asfifo_level.sv
// Scoreboard bench for asfifo_level: directed fill/drain/latency/reset
// sequences plus randomized traffic at three clock ratios.
`timescale 1ps/1ps
module tb_asfifo_level;
  localparam int unsigned DW = 8, AW = 4, SS = 2, DEPTH = 16, AF = 12, AE = 4;

  logic clk_write = 1'b0;
  logic clk_read  = 1'b0;
  logic preset_full = 1'b0;
  int   wr_half = 5000;
  int   rd_half = 15150;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] sb[$];
  bit   mon_on = 1'b0;
  bit   ovf_exp = 1'b0;
  bit   unf_exp = 1'b0;
  bit   wr_done;
  logic [DW-1:0] next_val = '0;

  asfifo_level_if #(.data_width(DW), .address_width(AW)) bus ();

  asfifo_level #(
    .data_width(DW), .address_width(AW), .sync_stages(SS),
    .almost_full_thresh(AF), .almost_empty_thresh(AE)
  ) dut (
    .clk_write(clk_write), .preset_full(preset_full), .clk_read(clk_read), .bus(bus)
  );

  initial forever #(wr_half) clk_write = ~clk_write;
  initial forever #(rd_half) clk_read  = ~clk_read;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every accepted word enters the scoreboard; overflow is
  // expected one edge after a write attempt while full.
  always @(negedge clk_write) begin
    if (mon_on) begin
      check("overflow_pulse", bus.overflow, ovf_exp);
      check("wr_level_bound", bus.wr_level <= DEPTH, 1);
    end
    if (bus.write_en === 1'b1 && bus.full === 1'b0) sb.push_back(bus.data_in);
    ovf_exp = !preset_full && bus.write_en === 1'b1 && bus.full === 1'b1;
  end

  // Read monitor: each pop must present the oldest outstanding word.
  always @(negedge clk_read) begin
    if (mon_on) begin
      check("underflow_pulse", bus.underflow, unf_exp);
      check("rd_level_bound", bus.rd_level <= DEPTH, 1);
    end
    if (bus.read_en === 1'b1 && bus.empty === 1'b0) begin
      if (sb.size() == 0) check("pop_with_nothing_written", 1, 0);
      else check("data_out", bus.data_out, sb.pop_front());
    end
    unf_exp = !preset_full && bus.read_en === 1'b1 && bus.empty === 1'b1;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_full"}, bus.full, 1);
    check({tag, "_almost_full"}, bus.almost_full, 1);
    check({tag, "_wr_level"}, bus.wr_level, 0);
    check({tag, "_overflow"}, bus.overflow, 0);
    check({tag, "_empty"}, bus.empty, 1);
    check({tag, "_almost_empty"}, bus.almost_empty, 1);
    check({tag, "_rd_level"}, bus.rd_level, 0);
    check({tag, "_underflow"}, bus.underflow, 0);
  endtask

  task automatic wait_full_release(input string tag);
    int n = 0;
    do begin @(posedge clk_write); #1; n++; end while (bus.full && n < 10);
    check({tag, "_full_release_edges"}, n <= SS + 1, 1);
    check({tag, "_full_after_release"}, bus.full, 0);
  endtask

  task automatic wait_rd_level(input string tag, input int lvl);
    int n = 0;
    @(posedge clk_read); #1;
    while (bus.rd_level != lvl && n < 40) begin @(posedge clk_read); #1; n++; end
    check(tag, bus.rd_level, lvl);
  endtask

  task automatic write_burst(input int cnt, input logic [DW-1:0] base);
    @(posedge clk_write); #1;
    for (int i = 0; i < cnt; i++) begin
      bus.write_en = 1'b1;
      bus.data_in  = base + DW'(i);
      @(posedge clk_write); #1;
    end
    bus.write_en = 1'b0;
  endtask

  task automatic drain_scoreboard(input string tag);
    int n = 0;
    @(posedge clk_read); #1;
    while (sb.size() != 0 && n < 20000) begin
      bus.read_en = 1'b1;
      @(posedge clk_read); #1; n++;
    end
    bus.read_en = 1'b0;
    check({tag, "_drained"}, sb.size(), 0);
  endtask

  task automatic random_phase(input int wh, input int rh, input int words);
    wr_half = wh; rd_half = rh; wr_done = 1'b0;
    fork
      begin
        int sent = 0;
        while (sent < words) begin
          @(posedge clk_write); #1;
          bus.write_en = 1'($urandom_range(0, 1));
          bus.data_in  = next_val;
          if (bus.write_en && !bus.full) begin next_val++; sent++; end
        end
        @(posedge clk_write); #1;
        bus.write_en = 1'b0;
        wr_done = 1'b1;
      end
      begin
        int cyc = 0;
        while (!(wr_done && sb.size() == 0) && cyc < 20000) begin
          @(posedge clk_read); #1;
          bus.read_en = 1'($urandom_range(0, 1));
          cyc++;
        end
        bus.read_en = 1'b0;
      end
    join
    check("random_phase_no_loss", sb.size(), 0);
  endtask

  initial begin
    repeat (5000) #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lvl;
    bus.write_en = 1'b0; bus.read_en = 1'b0; bus.data_in = '0;
    #100 preset_full = 1'b1;
    #1 check_reset_outputs("por");
    #30000 preset_full = 1'b0;
    wait_full_release("por");
    repeat (SS + 2) @(posedge clk_read);
    #1 mon_on = 1'b1;

    // Fill to depth, then one extra write which must be dropped.
    @(posedge clk_write); #1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      bus.write_en = 1'b1;
      bus.data_in  = DW'(i);
      @(posedge clk_write); #1;
      lvl = (i < DEPTH) ? i + 1 : DEPTH;
      check("fill_wr_level", bus.wr_level, lvl);
      check("fill_full", bus.full, lvl == DEPTH);
      check("fill_almost_full", bus.almost_full, lvl >= AF);
      check("fill_overflow", bus.overflow, i == DEPTH);
    end
    bus.write_en = 1'b0;

    // Drain all entries, then one extra read which must underflow.
    wait_rd_level("drain_start_rd_level", DEPTH);
    @(posedge clk_read); #1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      bus.read_en = 1'b1;
      @(posedge clk_read); #1;
      lvl = (i < DEPTH) ? DEPTH - 1 - i : 0;
      check("drain_rd_level", bus.rd_level, lvl);
      check("drain_empty", bus.empty, lvl == 0);
      check("drain_almost_empty", bus.almost_empty, lvl <= AE);
      check("drain_underflow", bus.underflow, i == DEPTH);
    end
    bus.read_en = 1'b0;
    check("drain_scoreboard_empty", sb.size(), 0);
    repeat (SS + 3) @(posedge clk_read);
    repeat (SS + 3) @(posedge clk_write);
    #1 check("drain_wr_level_zero", bus.wr_level, 0);

    // Single write into an empty FIFO: visibility latency on the read side.
    @(posedge clk_write); #1;
    bus.write_en = 1'b1; bus.data_in = 8'h5A;
    @(posedge clk_write); #1;
    bus.write_en = 1'b0;
    n = 0;
    do begin @(posedge clk_read); #1; n++; end while (bus.empty && n < 10);
    check("latency_edges_in_window", (n >= SS + 1) && (n <= SS + 2), 1);
    check("latency_rd_level", bus.rd_level, 1);
    drain_scoreboard("latency");

    // Reset with 9 entries queued; only post-reset data may come out.
    write_burst(9, 8'h30);
    #1 check("midreset_wr_level", bus.wr_level, 9);
    wait_rd_level("midreset_rd_level", 9);
    #3333 preset_full = 1'b1;
    #1 check_reset_outputs("midreset");
    sb.delete();
    #20000 preset_full = 1'b0;
    wait_full_release("midreset");
    repeat (SS + 2) @(posedge clk_read);
    write_burst(3, 8'hC0);
    drain_scoreboard("post_reset");

    // Random traffic, incrementing data, three clock ratios.
    random_phase(5000, 15150, 334);
    random_phase(15150, 5000, 334);
    random_phase(7000, 5030, 334);

    repeat (4) @(posedge clk_read);
    #1 check("final_scoreboard_empty", sb.size(), 0);
    check("final_empty", bus.empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
